// File: rtl/if_pc_redirect_pkg.sv
// if_pc_redirect_pkg: shared LC-3b fetch types and redirect decode
package if_pc_redirect_pkg;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {PCMUX_SEQ, PCMUX_BR, PCMUX_MEM, PCMUX_RSVD} lc3b_pcmux_sel;
  typedef enum logic [1:0] {FETCH, SQUASH, HOLD} lc3b_fetch_state;
  localparam lc3b_word CNT_MAX = 16'hFFFF;
  function automatic logic is_redirect(input logic be, input lc3b_pcmux_sel sel);
    return be && (sel == PCMUX_BR || sel == PCMUX_MEM);
  endfunction
endpackage

// File: rtl/if_pc_redirect_fetch_buffer.sv
// if_pc_redirect_fetch_buffer: single-entry pc/instr register with load, clear and valid
module if_pc_redirect_fetch_buffer
  import if_pc_redirect_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  lc3b_word pc_in,
  input  lc3b_word instr_in,
  output logic     valid,
  output lc3b_word pc,
  output lc3b_word instr
);
  always_ff @(posedge clk) begin
    if (reset || clear) valid <= 1'b0;
    else if (load) valid <= 1'b1;
    if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
    end
  end
endmodule

// File: rtl/if_pc_redirect.sv
// if_pc_redirect: fetch PC owner, I-mem handshake and EX redirect/squash handling
module if_pc_redirect
  import if_pc_redirect_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_enable,
  input  logic [1:0]  pcmux_sel,
  input  logic [15:0] br_addr,
  input  logic        id_stall,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr,
  output logic        flush,
  output logic [15:0] redirect_cnt
);
  lc3b_fetch_state state;
  lc3b_word pc, req_addr;
  logic redirect, buf_load, buf_clear, buf_valid;
  assign redirect     = !reset && is_redirect(branch_enable, lc3b_pcmux_sel'(pcmux_sel));
  assign flush        = redirect;
  assign buf_load     = !reset && state == FETCH && imem_resp && !redirect;
  assign buf_clear    = state == HOLD && (redirect || !id_stall);
  assign imem_read    = !reset && state != HOLD;
  // SQUASH keeps the abandoned request's address stable until its response arrives
  assign imem_address = state == SQUASH ? req_addr : pc;
  assign if_valid     = !reset && buf_valid && state == HOLD;
  if_pc_redirect_fetch_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .valid    (buf_valid),
    .pc       (if_pc),
    .instr    (if_instr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      redirect_cnt <= '0;
    end else begin
      if (redirect && redirect_cnt != CNT_MAX) redirect_cnt <= redirect_cnt + 16'd1;
      if (state == FETCH) req_addr <= pc;
      case (state)
        FETCH: begin
          if (redirect) begin
            pc    <= br_addr;
            state <= imem_resp ? FETCH : SQUASH;
          end else if (imem_resp) begin
            pc    <= pc + PC_INC;
            state <= HOLD;
          end
        end
        SQUASH: begin
          if (redirect) pc <= br_addr;
          if (imem_resp) state <= FETCH;
        end
        HOLD: begin
          if (redirect) pc <= br_addr;
          if (redirect || !id_stall) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_if_pc_redirect.sv
// tb_if_pc_redirect: directed vector table plus randomized run against a request/present model
module tb_if_pc_redirect;
  logic clk = 1'b0, reset, branch_enable, id_stall, imem_resp;
  logic [1:0] pcmux_sel;
  logic [15:0] br_addr, imem_rdata;
  logic imem_read, if_valid, flush;
  logic [15:0] imem_address, if_pc, if_instr, redirect_cnt;
  int total = 0, bad = 0;

  if_pc_redirect dut (
    .clk(clk), .reset(reset), .branch_enable(branch_enable), .pcmux_sel(pcmux_sel),
    .br_addr(br_addr), .id_stall(id_stall), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .flush(flush), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, be; logic [1:0] sel; logic [15:0] br; logic stall, resp; logic [15:0] rdata;
    logic e_read; logic [15:0] e_addr; logic e_valid; logic [15:0] e_pc, e_instr;
    logic e_flush; logic [15:0] e_cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, be, input logic [1:0] sel, input logic [15:0] br,
                     input logic stall, resp, input logic [15:0] rdata, input logic e_read,
                     input logic [15:0] e_addr, input logic e_valid, input logic [15:0] e_pc,
                     input logic [15:0] e_instr, input logic e_flush, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.be = be; v.sel = sel; v.br = br; v.stall = stall; v.resp = resp;
    v.rdata = rdata; v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_flush = e_flush; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, be, input logic [1:0] sel, input logic [15:0] br,
                       input logic stall, resp, input logic [15:0] rdata);
    reset = rst; branch_enable = be; pcmux_sel = sel; br_addr = br;
    id_stall = stall; imem_resp = resp; imem_rdata = rdata;
  endtask

  // model: either presenting a held instruction or requesting m_req (possibly already squashed)
  logic [15:0] m_pc, m_req, m_hpc, m_hins, m_cnt;
  logic m_hv, m_dead;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    //  rst be sel br       stl rsp rdata    rd addr     vld pc       instr    fl cnt
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h1234, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h1234, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1234, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1234, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1234, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1234, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h5555, 1, 16'h0004, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 16'h5555, 0, 16'd0);
    add(0, 1, 1, 16'h0040, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h0000, 16'h0000, 1, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h0000, 16'h0000, 0, 16'd1);
    add(0, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0006, 0, 16'h0000, 16'h0000, 0, 16'd1);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0, 16'd1);
    add(0, 1, 2, 16'h0100, 0, 1, 16'hBEEF, 1, 16'h0040, 0, 16'h0000, 16'h0000, 1, 16'd1);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'd2);
    add(0, 1, 1, 16'h0200, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 1, 16'd2);
    add(0, 1, 2, 16'h0300, 0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 1, 16'd3);
    add(0, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0100, 0, 16'h0000, 16'h0000, 0, 16'd4);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'd4);
    add(0, 1, 0, 16'h0500, 0, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'd4);
    add(0, 1, 3, 16'h0500, 0, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'd4);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0A0A, 1, 16'h0300, 0, 16'h0000, 16'h0000, 0, 16'd4);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0300, 16'h0A0A, 0, 16'd4);
    add(0, 1, 1, 16'hFFFE, 0, 0, 16'h0000, 1, 16'h0302, 0, 16'h0000, 16'h0000, 1, 16'd4);
    add(0, 0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0302, 0, 16'h0000, 16'h0000, 0, 16'd5);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h7777, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 0, 16'd5);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 16'h7777, 0, 16'd5);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd5);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h1111, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd5);
    add(0, 1, 1, 16'h0080, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h1111, 1, 16'd5);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0, 16'd6);
    add(0, 1, 1, 16'h0090, 0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 1, 16'd6);
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd7);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h2222, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'd0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h2222, 0, 16'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].be, vq[i].sel, vq[i].br, vq[i].stall, vq[i].resp, vq[i].rdata);
      #1;
      chk("imem_read", i, 16'(imem_read), 16'(vq[i].e_read));
      chk("flush", i, 16'(flush), 16'(vq[i].e_flush));
      chk("if_valid", i, 16'(if_valid), 16'(vq[i].e_valid));
      chk("redirect_cnt", i, redirect_cnt, vq[i].e_cnt);
      if (vq[i].e_read) chk("imem_address", i, imem_address, vq[i].e_addr);
      if (vq[i].e_valid) begin
        chk("if_pc", i, if_pc, vq[i].e_pc);
        chk("if_instr", i, if_instr, vq[i].e_instr);
      end
    end

    for (int n = 0; n < 4000; n++) begin
      logic rst, be, stall, resp, redir;
      logic [1:0] sel;
      logic [15:0] br, rdata;
      rst = (n == 0) || ($urandom_range(0, 99) == 0);
      be = ($urandom_range(0, 4) == 0);
      sel = 2'($urandom_range(0, 3));
      br = 16'($urandom) & 16'hFFFE;
      stall = 1'($urandom_range(0, 1));
      resp = ($urandom_range(0, 9) < 4);
      rdata = 16'($urandom);
      redir = be && (sel == 2'd1 || sel == 2'd2);
      @(negedge clk);
      drive(rst, be, sel, br, stall, resp, rdata);
      #1;
      if (n > 0) begin
        chk("rnd imem_read", n, 16'(imem_read), 16'(!rst && !m_hv));
        chk("rnd flush", n, 16'(flush), 16'(!rst && redir));
        chk("rnd if_valid", n, 16'(if_valid), 16'(!rst && m_hv));
        chk("rnd redirect_cnt", n, redirect_cnt, m_cnt);
        if (!rst && !m_hv) chk("rnd imem_address", n, imem_address, m_req);
        if (!rst && m_hv) begin
          chk("rnd if_pc", n, if_pc, m_hpc);
          chk("rnd if_instr", n, if_instr, m_hins);
        end
      end
      if (rst) begin
        m_pc = 16'h0000; m_req = 16'h0000; m_hv = 0; m_dead = 0; m_cnt = 0;
        m_hpc = 0; m_hins = 0;
      end else begin
        if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_hv) begin
          if (redir) begin m_hv = 0; m_pc = br; m_req = br; end
          else if (!stall) begin m_hv = 0; m_req = m_pc; end
        end else if (resp) begin
          if (m_dead || redir) begin
            m_dead = 0;
            if (redir) m_pc = br;
            m_req = m_pc;
          end else begin
            m_hv = 1; m_hpc = m_req; m_hins = rdata; m_pc = m_req + 16'd2;
          end
        end else if (redir) begin
          m_pc = br; m_dead = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
